// File: rtl/pc_sequencer_pkg.sv
// Shared fetch definitions for the next-PC sequencer: FSM encoding and
// default instruction size / reset vector.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

  localparam int FETCH_INSTR_BYTES = 4;
  localparam int FETCH_RESET_VEC   = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-address bundle between the pipeline and the PC sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic              halt;
  logic              resume;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_addr;
  logic              fetch_valid;
  logic              flush;
  logic              misaligned;
  logic [1:0]        state;

  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, halt, resume,
    input  pc, next_addr, fetch_valid, flush, misaligned, state
  );

  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, halt, resume,
    output pc, next_addr, fetch_valid, flush, misaligned, state
  );

endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, applies redirects immediately in RUN
// and buffers them while stalled or halted until fetch resumes.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              INSTR_BYTES = FETCH_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(FETCH_RESET_VEC)
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam int              ALIGN_B    = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_B) - 1);

  seq_state_t        state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              pend_vld_q, pend_vld_n;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_n;
  logic              pend_mis_q, pend_mis_n;
  logic              flush_q, flush_n;
  logic              mis_q, mis_n;

  logic              redirect;
  logic [ADDR_W-1:0] raw_tgt, tgt, seq_pc;
  logic              tgt_mis;

  // jmp wins over br_taken; low bits are dropped but remembered as misaligned
  always_comb begin
    redirect = bus.jmp | bus.br_taken;
    raw_tgt  = bus.jmp ? bus.jmp_target : bus.br_target;
    tgt      = raw_tgt & ~ALIGN_MASK;
    tgt_mis  = |(raw_tgt & ALIGN_MASK);
    seq_pc   = pc_q + ADDR_W'(INSTR_BYTES);
  end

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    pend_vld_n  = pend_vld_q;
    pend_addr_n = pend_addr_q;
    pend_mis_n  = pend_mis_q;
    flush_n     = 1'b0;
    mis_n       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_n    = tgt;
          flush_n = 1'b1;
          mis_n   = tgt_mis;
          state_n = bus.stall ? STALL : RUN;
        end else if (bus.halt) begin
          state_n = HALT;
        end else if (bus.stall) begin
          state_n = STALL;
        end else begin
          pc_n = seq_pc;
        end
      end

      STALL: begin
        if (bus.halt || bus.stall) begin
          if (bus.halt) state_n = HALT;
          if (redirect) begin
            pend_vld_n  = 1'b1;
            pend_addr_n = tgt;
            pend_mis_n  = tgt_mis;
          end
        end else begin
          state_n    = RUN;
          pend_vld_n = 1'b0;
          if (redirect) begin
            pc_n    = tgt;
            flush_n = 1'b1;
            mis_n   = tgt_mis;
          end else if (pend_vld_q) begin
            pc_n    = pend_addr_q;
            flush_n = 1'b1;
            mis_n   = pend_mis_q;
          end else begin
            pc_n = seq_pc;
          end
        end
      end

      HALT: begin
        // stall has no effect here; fetch restarts at the held pc on resume
        if (bus.resume) begin
          state_n    = RUN;
          pend_vld_n = 1'b0;
          if (redirect) begin
            pc_n    = tgt;
            flush_n = 1'b1;
            mis_n   = tgt_mis;
          end else if (pend_vld_q) begin
            pc_n    = pend_addr_q;
            flush_n = 1'b1;
            mis_n   = pend_mis_q;
          end
        end else if (redirect) begin
          pend_vld_n  = 1'b1;
          pend_addr_n = tgt;
          pend_mis_n  = tgt_mis;
        end
      end

      default: state_n = RUN;
    endcase

    // keeps next_addr truthful during reset as well
    if (rst) pc_n = RESET_VEC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_VEC;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_mis_q  <= 1'b0;
      flush_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      pend_vld_q  <= pend_vld_n;
      pend_addr_q <= pend_addr_n;
      pend_mis_q  <= pend_mis_n;
      flush_q     <= flush_n;
      mis_q       <= mis_n;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.next_addr   = pc_n;
  assign bus.fetch_valid = !rst && (state_q == RUN) && !bus.stall;
  assign bus.flush       = flush_q;
  assign bus.misaligned  = mis_q;
  assign bus.state       = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the instruction-fetch stage. It owns the program-counter register and decides each cycle whether fetch advances sequentially, redirects to a branch or jump target, stalls, or halts. Redirects that arrive while fetch is frozen are buffered and applied when fetch resumes. It drives the instruction-memory address and tells the pipeline when fetched words are valid and when younger instructions must be flushed.

## Interface
Parameters:
- ADDR_W, 8, address width in bits; byte addresses.
- INSTR_BYTES, 4, sequential increment.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch this cycle; the PC does not advance.
- br_taken  in  1  a resolved branch is taken this cycle.
- br_target  in  ADDR_W  branch destination.
- jmp  in  1  unconditional jump this cycle.
- jmp_target  in  ADDR_W  jump destination.
- halt  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- pc  out  ADDR_W  current fetch address; registered.
- next_addr  out  ADDR_W  value pc will take at the next edge; combinational.
- fetch_valid  out  1  the instruction at pc is a real fetch this cycle.
- flush  out  1  registered one-cycle pulse after pc has loaded a redirect.
- misaligned  out  1  registered one-cycle pulse, concurrent with flush, when the applied target had nonzero low bits.
- state  out  2  debug view of the FSM.

## Operation
- **FSM states:** RUN=0, STALL=1, HALT=2.
- **Redirect definition:**
  - redirect = jmp | br_taken.
  - The target is jmp_target if jmp is set, else br_target. jmp beats br_taken when both are set.
- **Redirect target alignment:** the low log2(INSTR_BYTES) bits of the target are forced to 0. misaligned is set if any of those bits were 1.
- **Priority:** rst > redirect > halt > stall > sequential.
- **RUN:**
  - On redirect: pc <= target and flush pulses. This applies even if stall or halt is also asserted. halt is dropped that cycle.
  - Else on halt: go to HALT; pc holds.
  - Else on stall: go to STALL; pc holds.
  - Else: pc <= pc + INSTR_BYTES, modulo 2^ADDR_W.
- **STALL:**
  - pc holds.
  - On redirect: capture the target in a pending register (pend_vld=1, pend_addr, pend_mis). A newer redirect overwrites an older pending one.
  - On halt: go to HALT; pending is retained.
  - When stall=0 and there is no halt, return to RUN and apply, in priority order:
    - a same-cycle redirect, which discards pending;
    - else pending, which pulses flush and clears pend_vld;
    - else pc + INSTR_BYTES.
- **HALT:**
  - pc holds.
  - Redirects are captured into pending, same rules as STALL.
  - On resume: go to RUN and apply pending if pend_vld, else hold pc. Fetch restarts at the held address.
  - stall is ignored in HALT.
- **fetch_valid** = !rst & (state==RUN) & !stall.
- **next_addr** always equals the value pc will load at the next edge, including hold cases.
- **Reset** (at any point, mid-redirect included):
  - pc=RESET_VEC, state=RUN.
  - pend_vld=0; pending is dropped.
  - flush=0, misaligned=0.

## Timing
- Redirect latency: pc = target exactly one edge after the redirect cycle. flush and misaligned are high for the single following cycle.
- Pending redirect latency: applied on the edge that ends the stall or halt (the cycle in which stall=0 or resume=1). flush follows one cycle later.
- Sequential wrap: pc=8'hFC advances to 8'h00, with no flag raised.
- Simultaneous redirect + stall in RUN: the redirect is taken immediately, state moves to STALL, and no pending entry is made.
- Simultaneous resume + redirect in HALT: the redirect is applied and pending is discarded.
- First cycle after rst deasserts: pc=RESET_VEC and fetch_valid=1 unless stall is asserted.

## Structure
- Shared fetch package holds:
  - the state encoding constants RUN, STALL, HALT;
  - INSTR_BYTES;
  - RESET_VEC.
- No sub-module is needed; the pending-redirect register is inline.
- One always block handles the sequential state. One combinational block computes next_addr and the next state.

## Test plan
- **Reset then run:** rst high for 2 cycles, then 4 idle cycles → pc sequence 0, 4, 8, 12, 16; fetch_valid=1 throughout.
- **Branch while running:** jmp=0, br_taken=1, br_target=8'h40 at pc=8 → pc=8'h40 next cycle; flush=1 for one cycle, misaligned=0.
- **Redirect buffered during stall:**
  - stall=1 for 3 cycles starting at pc=8'h10;
  - br_target=8'h22 with br_taken pulsed during cycle 2.
  - Required: pc holds at 8'h10; after release pc=8'h20, flush=1, misaligned=1.
- **Newest pending wins:** during a stall, jmp to 8'h80, then a later br to 8'h30 → pc=8'h30 on release.
- **Halt and resume:** halt at pc=8'h0C → pc holds and fetch_valid=0; resume → fetch_valid=1 and pc advances 8'h0C, 8'h10. Then halt together with jmp to 8'h50 → pc=8'h50 and state remains RUN.
- **Wrap and mid-operation reset:**
  - Run from pc=8'hF8 → 8'hFC, then 8'h00.
  - Assert rst while pend_vld=1 → pc=0, pend_vld=0, and no flush after reset.
